// File: rtl/sd_nios2_attempt_mem_xfer_master.sv
// Avalon-MM block mover between a valid/ready stream and the on-chip memory.
// Write commands drain the sink stream into memory; read commands fill the source stream.
module sd_nios2_attempt_mem_xfer_master #(
    parameter int unsigned ADDR_W       = 14,
    parameter int unsigned LEN_W        = 15,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       sink_data,
    input  logic              sink_valid,
    output logic              sink_ready,
    output logic [31:0]       src_data,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                  state, state_next;
    logic [ADDR_W-1:0]       addr, base_addr;
    logic [LEN_W-1:0]        remaining, base_rem;
    logic [READ_LATENCY-1:0] lat_sr;
    logic [31:0]             fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [CNT_W-1:0]        fifo_count, used;
    logic                    cmd_acc, sink_hs, present, hold, issue, push, pop;

    assign avm_byteenable = 4'hF;
    assign src_valid      = (fifo_count != '0);
    assign src_data       = fifo_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    // used = presented + in-flight reads + FIFO words; bounds reads to FIFO space
    always_comb begin
        state_next = state;
        cmd_acc    = 1'b0;
        sink_ready = 1'b0;
        sink_hs    = 1'b0;
        present    = 1'b0;
        base_addr  = addr;
        base_rem   = remaining;
        hold       = avm_chipselect & avm_waitrequest;
        issue      = avm_chipselect & ~avm_write & ~avm_waitrequest;
        push       = lat_sr[READ_LATENCY-1];
        pop        = src_valid & src_ready;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_acc   = 1'b1;
                    base_addr = cmd_addr;
                    base_rem  = cmd_len;
                    if (cmd_len == '0) begin
                        state_next = S_DONE;
                    end else if (cmd_write) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_READ;
                        present    = 1'b1;
                    end
                end
            end
            S_WRITE: begin
                sink_ready = (remaining != '0) && !hold;
                sink_hs    = sink_valid & sink_ready;
                if (remaining == '0 && !hold) state_next = S_DONE;
            end
            S_READ: begin
                if (remaining != '0 && !hold && (used < CNT_W'(FIFO_DEPTH) || pop))
                    present = 1'b1;
                if (remaining == '0 && !hold) state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (used == '0) state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr           <= '0;
            remaining      <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_writedata  <= '0;
            lat_sr         <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            fifo_count     <= '0;
            used           <= '0;
            busy           <= 1'b0;
            cmd_ready      <= 1'b1;
            done           <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (cmd_acc) begin
                addr      <= cmd_addr;
                remaining <= cmd_len;
            end
            // New access launches; a stalled one stays on the bus untouched
            if (present || sink_hs) begin
                avm_chipselect <= 1'b1;
                avm_write      <= sink_hs;
                avm_address    <= base_addr;
                addr           <= base_addr + ADDR_W'(1);
                remaining      <= base_rem - LEN_W'(1);
            end else if (!hold) begin
                avm_chipselect <= 1'b0;
                avm_write      <= 1'b0;
            end
            if (sink_hs) avm_writedata <= sink_data;

            lat_sr <= (lat_sr << 1) | READ_LATENCY'(issue);
            if (push) begin
                fifo_mem[wr_ptr] <= avm_readdata;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            used       <= used + CNT_W'(present) - CNT_W'(pop);

            busy      <= (state_next != S_IDLE);
            cmd_ready <= (state_next == S_IDLE);
            done      <= (state == S_DONE);
        end
    end

endmodule

// File: tb/tb_sd_nios2_attempt_mem_xfer_master.sv
// Directed bench: word-addressed memory model with READ_LATENCY = 1 and
// controllable waitrequest; write/read streams are logged and checked in order.
module tb_sd_nios2_attempt_mem_xfer_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [13:0] cmd_addr;
    logic [14:0] cmd_len;
    logic [31:0] sink_data;
    logic        sink_valid, sink_ready;
    logic [31:0] src_data;
    logic        src_valid, src_ready;
    logic [13:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_chipselect, avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest;
    logic        busy, done;

    int tests = 0;
    int failed = 0;

    sd_nios2_attempt_mem_xfer_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .avm_address(avm_address), .avm_byteenable(avm_byteenable),
        .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Memory model: unwritten words return a fixed address pattern
    logic [31:0] mem     [0:16383];
    bit          wr_flag [0:16383];
    int          cyc = 0, acc_cnt = 0, rd_issued = 0, popped = 0, done_cnt = 0, max_out = 0;
    logic [31:0] wq_addr[$], wq_data[$], src_q[$];
    int          wq_cyc[$], src_cyc[$];

    function automatic logic [31:0] pat(input int a);
        return 32'h5EED_0000 ^ 32'(a);
    endfunction
    function automatic logic [31:0] word_a(input int i);
        return 32'hA0A0_0000 + 32'(i);
    endfunction
    function automatic logic [31:0] word_b(input int i);
        return 32'hB0B0_0000 + 32'(i);
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_chipselect && !avm_waitrequest) begin
            acc_cnt <= acc_cnt + 1;
            if (avm_write) begin
                mem[avm_address]     <= avm_writedata;
                wr_flag[avm_address] <= 1'b1;
                wq_addr.push_back(32'(avm_address));
                wq_data.push_back(avm_writedata);
                wq_cyc.push_back(cyc);
            end else begin
                avm_readdata <= wr_flag[avm_address] ? mem[avm_address] : pat(int'(avm_address));
                rd_issued    <= rd_issued + 1;
            end
        end
        if (src_valid && src_ready) begin
            src_q.push_back(src_data);
            src_cyc.push_back(cyc);
            popped <= popped + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    always @(negedge clk) begin
        if (rd_issued - popped > max_out) max_out <= rd_issued - popped;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] q_at(input int idx, input int sel);
        if (sel == 0) return (idx < wq_addr.size()) ? wq_addr[idx] : 32'hDEAD_BEEF;
        if (sel == 1) return (idx < wq_data.size()) ? wq_data[idx] : 32'hDEAD_BEEF;
        return (idx < src_q.size()) ? src_q[idx] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int wb, sb, ab, db, first, idx, k;
        bit hs;

        // Reset held with a command pending
        reset_n = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 14'h0010; cmd_len = 15'd4;
        sink_valid = 1'b0; sink_data = '0; src_ready = 1'b0; avm_waitrequest = 1'b0;
        repeat (3) step();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_chipselect", 32'(avm_chipselect), 32'd0);
        check("rst_src_valid", 32'(src_valid), 32'd0);
        check("rst_byteenable", 32'(avm_byteenable), 32'hF);
        check("rst_sink_ready", 32'(sink_ready), 32'd0);

        // Write 4 words at 0x10
        wb = wq_addr.size(); db = done_cnt;
        reset_n = 1'b1;
        step();
        check("wr_accept_busy", 32'(busy), 32'd1);
        check("wr_accept_cmd_ready", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sink_valid = 1'b1;
            sink_data  = word_a(i);
            check($sformatf("wr_sink_ready_%0d", i), 32'(sink_ready), 32'd1);
            step();
        end
        sink_valid = 1'b0;
        wait_done("wr_done");
        check("wr_busy_at_done", 32'(busy), 32'd0);
        step();
        check("wr_done_pulse_end", 32'(done), 32'd0);
        check("wr_done_count", 32'(done_cnt - db), 32'd1);
        check("wr_count", 32'(wq_addr.size() - wb), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr_addr_%0d", i), q_at(wb + i, 0), 32'h10 + 32'(i));
            check($sformatf("wr_data_%0d", i), q_at(wb + i, 1), word_a(i));
        end
        check("wr_back_to_back", 32'((wq_cyc.size() >= wb + 4) ? wq_cyc[wb + 3] - wq_cyc[wb] : -1), 32'd3);

        // Read back 4 words from 0x10
        sb = src_q.size();
        src_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h0010; cmd_len = 15'd4;
        step();
        cmd_valid = 1'b0;
        first = 0;
        for (int i = 1; i <= 3; i++) begin
            if (first == 0 && src_valid === 1'b1) first = i;
            if (i < 3) step();
        end
        check("rd_first_valid_by_3", 32'(first != 0), 32'd1);
        wait_done("rd_done");
        check("rd_count", 32'(src_q.size() - sb), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rd_data_%0d", i), q_at(sb + i, 2), word_a(i));
        check("rd_one_per_cycle", 32'((src_cyc.size() >= sb + 4) ? src_cyc[sb + 3] - src_cyc[sb] : -1), 32'd3);

        // Read 16 words with backpressure 1-0-0-1
        sb = src_q.size();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h0100; cmd_len = 15'd16;
        step();
        cmd_valid = 1'b0;
        k = 0;
        while (done !== 1'b1 && k < 400) begin
            src_ready = (k % 4 == 0) || (k % 4 == 3);
            step();
            k++;
        end
        check("bp_done", 32'(done), 32'd1);
        src_ready = 1'b1;
        check("bp_count", 32'(src_q.size() - sb), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("bp_data_%0d", i), q_at(sb + i, 2), pat(16'h100 + i));
        check("bp_max_outstanding", 32'(max_out), 32'd4);

        // Wrapping write with a 2-cycle stall after the first word
        wb = wq_addr.size(); ab = acc_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 14'h3FFE; cmd_len = 15'd3;
        step();
        cmd_valid = 1'b0;
        idx = 0; k = 1;
        while (done !== 1'b1 && k < 60) begin
            avm_waitrequest = (k == 2 || k == 3);
            sink_valid      = (idx < 3);
            sink_data       = word_b(idx);
            #1;
            if (k == 2 || k == 3) begin
                check($sformatf("wait_cs_k%0d", k), 32'(avm_chipselect), 32'd1);
                check($sformatf("wait_addr_k%0d", k), 32'(avm_address), 32'h3FFE);
                check($sformatf("wait_data_k%0d", k), avm_writedata, word_b(0));
                check($sformatf("wait_sink_ready_k%0d", k), 32'(sink_ready), 32'd0);
            end
            hs = sink_valid && sink_ready;
            step();
            if (hs) idx++;
            k++;
        end
        avm_waitrequest = 1'b0; sink_valid = 1'b0;
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_count", 32'(wq_addr.size() - wb), 32'd3);
        check("wrap_access_count", 32'(acc_cnt - ab), 32'd3);
        check("wrap_addr_0", q_at(wb, 0), 32'h3FFE);
        check("wrap_addr_1", q_at(wb + 1, 0), 32'h3FFF);
        check("wrap_addr_2", q_at(wb + 2, 0), 32'h0000);
        for (int i = 0; i < 3; i++)
            check($sformatf("wrap_data_%0d", i), q_at(wb + i, 1), word_b(i));
        step();

        // Zero-length command
        ab = acc_cnt; db = done_cnt;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h0040; cmd_len = 15'd0;
        step();
        cmd_valid = 1'b0;
        check("len0_busy_c1", 32'(busy), 32'd1);
        check("len0_done_c1", 32'(done), 32'd0);
        step();
        check("len0_done_c2", 32'(done), 32'd1);
        check("len0_idle_c2", 32'(cmd_ready), 32'd1);
        step();
        check("len0_done_c3", 32'(done), 32'd0);
        check("len0_no_access", 32'(acc_cnt - ab), 32'd0);
        check("len0_done_count", 32'(done_cnt - db), 32'd1);

        // Reset in the middle of a 10-word read
        sb = src_q.size();
        src_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h0200; cmd_len = 15'd10;
        step();
        cmd_valid = 1'b0;
        k = 0;
        while (src_q.size() - sb < 5 && k < 100) begin
            step();
            k++;
        end
        check("mid_five_words", 32'(src_q.size() - sb >= 5), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_cs", 32'(avm_chipselect), 32'd0);
        check("mid_rst_write", 32'(avm_write), 32'd0);
        check("mid_rst_addr", 32'(avm_address), 32'd0);
        check("mid_rst_src_valid", 32'(src_valid), 32'd0);
        check("mid_rst_src_data", src_data, 32'd0);
        step();
        reset_n = 1'b1;
        sb = src_q.size();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 14'h0010; cmd_len = 15'd2;
        step();
        cmd_valid = 1'b0;
        check("post_rst_accept", 32'(busy), 32'd1);
        wait_done("post_rst_done");
        check("post_rst_count", 32'(src_q.size() - sb), 32'd2);
        check("post_rst_data_0", q_at(sb, 2), word_a(0));
        check("post_rst_data_1", q_at(sb + 1, 2), word_a(1));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
